// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes ALUOp/Funct3/Funct7 into the ALU operation code
// and pushes {code, illegal, SrcA, SrcB, tag} through a 2-entry valid/ready skid
// buffer. The head entry drives the outputs directly from registers.
module alu_issue_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic [DATA_WIDTH-1:0]    in_srca,
  input  logic [DATA_WIDTH-1:0]    in_srcb,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic                     out_illegal,
  output logic [CNT_WIDTH-1:0]     illegal_count
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_LUI = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1110);
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] op;
    logic                     ill;
    logic [DATA_WIDTH-1:0]    a;
    logic [DATA_WIDTH-1:0]    b;
    logic [TAG_WIDTH-1:0]     tag;
  } entry_t;

  logic [OPCODE_LENGTH-1:0] dec_op;
  logic                     dec_ill;
  entry_t                   head, tail, new_ent;
  logic [1:0]               cnt, cnt_nxt;
  logic                     push, pop;

  // Decode ALUOp/Funct3/Funct7; anything not listed falls to the illegal code.
  always_comb begin
    dec_op = OP_ILL;
    case (ALUOp)
      3'b000: dec_op = OP_ADD;
      3'b100: dec_op = OP_LUI;
      3'b001: begin
        if (Funct3 == 3'b000 || Funct3 == 3'b001) dec_op = OP_EQ;
        else if (Funct3 == 3'b100)                dec_op = OP_SLT;
      end
      3'b010: begin
        case (Funct3)
          3'b000: if (Funct7 == 7'h00) dec_op = OP_ADD;
                  else if (Funct7 == 7'h20) dec_op = OP_SUB;
          3'b001: if (Funct7 == 7'h00) dec_op = OP_SLL;
          3'b010: if (Funct7 == 7'h00) dec_op = OP_SLT;
          3'b100: if (Funct7 == 7'h00) dec_op = OP_XOR;
          3'b101: if (Funct7 == 7'h00) dec_op = OP_SRL;
                  else if (Funct7 == 7'h20) dec_op = OP_SRA;
          3'b110: if (Funct7 == 7'h00) dec_op = OP_OR;
          3'b111: if (Funct7 == 7'h00) dec_op = OP_AND;
          default: dec_op = OP_ILL;
        endcase
      end
      3'b011: begin
        // Immediate forms ignore Funct7 except for the shifts, where it selects/validates.
        case (Funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: if (Funct7 == 7'h00) dec_op = OP_SLL;
          3'b101: if (Funct7 == 7'h00) dec_op = OP_SRL;
                  else if (Funct7 == 7'h20) dec_op = OP_SRA;
          default: dec_op = OP_ILL;
        endcase
      end
      default: dec_op = OP_ILL;
    endcase
    dec_ill = (dec_op == OP_ILL);
  end

  assign new_ent = '{op: dec_op, ill: dec_ill, a: in_srca, b: in_srcb, tag: in_tag};
  assign push    = in_valid & in_ready & ~flush;
  assign pop     = out_valid & out_ready & ~flush;

  // Occupancy next-state; flush empties the buffer regardless of handshakes.
  always_comb begin
    cnt_nxt = cnt;
    if (flush)              cnt_nxt = 2'd0;
    else if (push && !pop)  cnt_nxt = cnt + 2'd1;
    else if (pop && !push)  cnt_nxt = cnt - 2'd1;
  end

  // Buffer storage plus registered handshake flags derived from next occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 2'd0;
      head      <= '0;
      tail      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      cnt       <= cnt_nxt;
      out_valid <= (cnt_nxt != 2'd0);
      in_ready  <= (cnt_nxt != 2'd2);
      if (!flush) begin
        case (cnt)
          2'd0: if (push) head <= new_ent;
          2'd1: begin
            // With one entry a push alongside a pop becomes the new head directly.
            if (push && pop) head <= new_ent;
            else if (push)   tail <= new_ent;
          end
          2'd2: if (pop) head <= tail;
          default: ;
        endcase
      end
    end
  end

  // Saturating count of accepted illegal entries; flush never touches it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal_count <= '0;
    else if (push && dec_ill && (illegal_count != {CNT_WIDTH{1'b1}}))
      illegal_count <= illegal_count + CNT_WIDTH'(1);
  end

  assign Operation   = head.op;
  assign out_illegal = head.ill;
  assign SrcA        = head.a;
  assign SrcB        = head.b;
  assign out_tag     = head.tag;

endmodule
